// File: rtl/thread_trap_ctrl_if.sv
// thread_trap_ctrl_if: groups the trap-request, commit and trap-report signals
// of the per-thread trap controller into one bundle.
//
// Optional feature macro: THREAD_TRAP_IRQ_EN (adds the irq_* request group).
//
// Signals:
//   req_valid/req_tid/req_vec/req_ticc   trap request from execute/memory stages
//   cmt_valid/cmt_tid/cmt_et/cmt_flush   commit of a thread
//   irq_valid/irq_tid/irq_level/irq_pil  interrupt request (THREAD_TRAP_IRQ_EN only)
//   trap_valid/err_valid/trap_tid/trap_tt  registered trap / error-mode event
//   err_mode/pend                        per-thread sticky error flags / pending flags
//
// Modports:
//   master - pipeline side, drives requests and commits
//   slave  - trap controller side, drives the trap report and status vectors
interface thread_trap_ctrl_if #(
  parameter int NTHREAD = 64,
  parameter int TIDW    = 6,
  parameter int TTW     = 8
);
  logic               req_valid;
  logic [TIDW-1:0]    req_tid;
  logic [12:0]        req_vec;
  logic [6:0]         req_ticc;

  logic               cmt_valid;
  logic [TIDW-1:0]    cmt_tid;
  logic               cmt_et;
  logic               cmt_flush;

`ifdef THREAD_TRAP_IRQ_EN
  logic               irq_valid;
  logic [TIDW-1:0]    irq_tid;
  logic [3:0]         irq_level;
  logic [3:0]         irq_pil;
`endif

  logic               trap_valid;
  logic [TIDW-1:0]    trap_tid;
  logic [TTW-1:0]     trap_tt;
  logic               err_valid;
  logic [NTHREAD-1:0] err_mode;
  logic [NTHREAD-1:0] pend;

`ifdef THREAD_TRAP_IRQ_EN
  modport master (
    output req_valid, req_tid, req_vec, req_ticc,
    output cmt_valid, cmt_tid, cmt_et, cmt_flush,
    output irq_valid, irq_tid, irq_level, irq_pil,
    input  trap_valid, trap_tid, trap_tt, err_valid, err_mode, pend
  );

  modport slave (
    input  req_valid, req_tid, req_vec, req_ticc,
    input  cmt_valid, cmt_tid, cmt_et, cmt_flush,
    input  irq_valid, irq_tid, irq_level, irq_pil,
    output trap_valid, trap_tid, trap_tt, err_valid, err_mode, pend
  );
`else
  modport master (
    output req_valid, req_tid, req_vec, req_ticc,
    output cmt_valid, cmt_tid, cmt_et, cmt_flush,
    input  trap_valid, trap_tid, trap_tt, err_valid, err_mode, pend
  );

  modport slave (
    input  req_valid, req_tid, req_vec, req_ticc,
    input  cmt_valid, cmt_tid, cmt_et, cmt_flush,
    output trap_valid, trap_tid, trap_tt, err_valid, err_mode, pend
  );
`endif

endinterface

// File: rtl/thread_trap_ctrl.sv
// thread_trap_ctrl: per-thread trap collection and prioritisation for the
// multithreaded SPARC V8 integer pipeline.
//
// Each thread keeps the highest-priority trap requested so far (TT plus a
// 4-bit rank, 0 = highest). When the thread commits, the pending trap is
// reported one cycle later as trap_valid (PSR.ET=1) or err_valid (PSR.ET=0,
// which also sets the sticky err_mode flag of that thread).
//
// Optional feature macro: THREAD_TRAP_IRQ_EN (interrupt requests as a
// lowest-rank trap candidate, TT = 0x10 + level).
//
// Ports:
//   gclk  - pipeline clock
//   rstn  - synchronous active-low reset
//   bus   - thread_trap_ctrl_if.slave (requests, commits, trap report, status)
module thread_trap_ctrl #(
  parameter int NTHREAD = 64,
  parameter int TIDW    = 6,
  parameter int TTW     = 8
) (
  input  logic                gclk,
  input  logic                rstn,
  thread_trap_ctrl_if.slave   bus
);

  localparam logic [3:0] RANK_IRQ = 4'd13;

  // ---------------------------------------------------------------------------
  // Request candidate: the lowest set bit of req_vec is the highest-priority
  // class, so a plain priority chain gives rank = bit index.
  // ---------------------------------------------------------------------------
  logic           req_hit;
  logic [3:0]     req_rank;
  logic [TTW-1:0] req_tt;

  always_comb begin
    req_hit  = bus.req_valid && (bus.req_vec != 13'd0);
    req_rank = 4'd0;
    req_tt   = '0;
    if (bus.req_vec[0]) begin
      req_rank = 4'd0;  req_tt = TTW'(8'h01);   // IAEX
    end else if (bus.req_vec[1]) begin
      req_rank = 4'd1;  req_tt = TTW'(8'h03);   // PRIV
    end else if (bus.req_vec[2]) begin
      req_rank = 4'd2;  req_tt = TTW'(8'h02);   // IINST
    end else if (bus.req_vec[3]) begin
      req_rank = 4'd3;  req_tt = TTW'(8'h04);   // FPDIS
    end else if (bus.req_vec[4]) begin
      req_rank = 4'd4;  req_tt = TTW'(8'h24);   // CPDIS
    end else if (bus.req_vec[5]) begin
      req_rank = 4'd5;  req_tt = TTW'(8'h05);   // WINOF
    end else if (bus.req_vec[6]) begin
      req_rank = 4'd6;  req_tt = TTW'(8'h06);   // WINUF
    end else if (bus.req_vec[7]) begin
      req_rank = 4'd7;  req_tt = TTW'(8'h07);   // UNALA
    end else if (bus.req_vec[8]) begin
      req_rank = 4'd8;  req_tt = TTW'(8'h08);   // FPEXC
    end else if (bus.req_vec[9]) begin
      req_rank = 4'd9;  req_tt = TTW'(8'h09);   // DAEX
    end else if (bus.req_vec[10]) begin
      req_rank = 4'd10; req_tt = TTW'(8'h0A);   // TAG
    end else if (bus.req_vec[11]) begin
      req_rank = 4'd11; req_tt = TTW'(8'h2A);   // DIVZ
    end else if (bus.req_vec[12]) begin
      req_rank = 4'd12; req_tt = TTW'({1'b1, bus.req_ticc});  // TICC
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt candidate. Without the feature the IRQ path is tied off and
  // never selected.
  // ---------------------------------------------------------------------------
  logic            irq_hit;
  logic [TIDW-1:0] irq_tid;
  logic [TTW-1:0]  irq_tt;

`ifdef THREAD_TRAP_IRQ_EN
  always_comb begin
    irq_hit = bus.irq_valid &&
              ((bus.irq_level > bus.irq_pil) || (bus.irq_level == 4'hF));
    irq_tid = bus.irq_tid;
    irq_tt  = TTW'(8'h10) + TTW'(bus.irq_level);
  end
`else
  always_comb begin
    irq_hit = 1'b0;
    irq_tid = '0;
    irq_tt  = '0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Per-thread state and bypass merge. eff_* is the pending state a commit in
  // this cycle sees: stored trap merged with any same-cycle request/irq.
  // ---------------------------------------------------------------------------
  logic [NTHREAD-1:0] pend_all;
  logic [NTHREAD-1:0] err_all;
  logic [NTHREAD-1:0] eff_pend_all;
  logic [TTW-1:0]     eff_tt_all [NTHREAD];

  for (genvar gi = 0; gi < NTHREAD; gi++) begin : g_thread
    logic           pend_reg;
    logic           err_reg;
    logic [TTW-1:0] tt_reg;
    logic [3:0]     rank_reg;

    logic           req_sel;
    logic           irq_sel;
    logic           in_valid;
    logic [3:0]     in_rank;
    logic [TTW-1:0] in_tt;
    logic           take;
    logic           cmt_sel;
    logic           err_set;

    always_comb begin
      req_sel  = req_hit && (bus.req_tid == TIDW'(gi));
      irq_sel  = irq_hit && (irq_tid == TIDW'(gi));
      in_valid = req_sel || irq_sel;
      // Any trap-class request outranks an interrupt, so a same-cycle
      // req/irq pair on one thread resolves to the request.
      in_rank  = req_sel ? req_rank : RANK_IRQ;
      in_tt    = req_sel ? req_tt   : irq_tt;
      // Strictly-better rule: on a tie the trap already stored stays.
      take     = in_valid && (!pend_reg || (in_rank < rank_reg));
      cmt_sel  = bus.cmt_valid && (bus.cmt_tid == TIDW'(gi));
      err_set  = cmt_sel && !bus.cmt_flush && (pend_reg || in_valid) && !bus.cmt_et;
    end

    assign eff_pend_all[gi] = pend_reg || in_valid;
    assign eff_tt_all[gi]   = take ? in_tt : tt_reg;
    assign pend_all[gi]     = pend_reg;
    assign err_all[gi]      = err_reg;

    always_ff @(posedge gclk) begin
      if (!rstn) begin
        pend_reg <= 1'b0;
        err_reg  <= 1'b0;
        tt_reg   <= '0;
        rank_reg <= 4'd0;
      end else begin
        // A commit of this thread always clears pend, even when a request
        // for the same thread arrives in the same cycle (it was merged into
        // the committed trap or discarded by the flush).
        pend_reg <= (pend_reg || in_valid) && !cmt_sel;
        if (err_set) begin
          err_reg <= 1'b1;
        end
        if (take) begin
          tt_reg   <= in_tt;
          rank_reg <= in_rank;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit report, registered: one-cycle pulse after the commit.
  // ---------------------------------------------------------------------------
  logic            cmt_pend;
  logic [TTW-1:0]  cmt_tt;
  logic            fire;

  logic            trap_valid_reg;
  logic            err_valid_reg;
  logic [TIDW-1:0] trap_tid_reg;
  logic [TTW-1:0]  trap_tt_reg;

  always_comb begin
    cmt_pend = eff_pend_all[bus.cmt_tid];
    cmt_tt   = eff_tt_all[bus.cmt_tid];
    fire     = bus.cmt_valid && !bus.cmt_flush && cmt_pend;
  end

  always_ff @(posedge gclk) begin
    if (!rstn) begin
      trap_valid_reg <= 1'b0;
      err_valid_reg  <= 1'b0;
      trap_tid_reg   <= '0;
      trap_tt_reg    <= '0;
    end else begin
      trap_valid_reg <= fire && bus.cmt_et;
      err_valid_reg  <= fire && !bus.cmt_et;
      trap_tid_reg   <= fire ? bus.cmt_tid : '0;
      trap_tt_reg    <= fire ? cmt_tt : '0;
    end
  end

  assign bus.trap_valid = trap_valid_reg;
  assign bus.err_valid  = err_valid_reg;
  assign bus.trap_tid   = trap_tid_reg;
  assign bus.trap_tt    = trap_tt_reg;
  assign bus.err_mode   = err_all;
  assign bus.pend       = pend_all;

endmodule

// File: tb/tb_thread_trap_ctrl.sv
// tb_thread_trap_ctrl: scoreboard bench for thread_trap_ctrl.
// A stimulus process drives one input set per cycle (on the falling edge) and
// updates a per-thread behavioural model, pushing expected trap reports and
// expected pend/err_mode snapshots into queues. A separate monitor samples
// the DUT just after each rising edge and compares against those queues.
// Optional feature macro: THREAD_TRAP_IRQ_EN.
module tb_thread_trap_ctrl;

  localparam int NT = 64;

  logic gclk = 1'b0;
  logic rstn = 1'b0;
  always #5 gclk = ~gclk;

  thread_trap_ctrl_if #(.NTHREAD(NT), .TIDW(6), .TTW(8)) bus_if ();

  thread_trap_ctrl #(.NTHREAD(NT), .TIDW(6), .TTW(8)) dut (
    .gclk (gclk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge gclk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  bit        m_pend [NT];
  bit [7:0]  m_tt   [NT];
  int        m_rank [NT];
  bit [63:0] m_err;
  bit [7:0]  tt_tab [13] = '{8'h01, 8'h03, 8'h02, 8'h04, 8'h24, 8'h05, 8'h06,
                             8'h07, 8'h08, 8'h09, 8'h0A, 8'h2A, 8'h00};

  typedef struct { int cyc; bit err; int tid; bit [7:0] tt; } exp_t;
  typedef struct { int cyc; bit [63:0] pend; bit [63:0] err; } snap_t;
  exp_t  exp_q [$];
  snap_t snap_q [$];

  // Inputs applied by the next step() call.
  bit       rst_lvl   = 1'b0;
  bit       irq_v     = 1'b0;
  int       irq_t     = 0;
  bit [3:0] irq_lvl   = 4'd0;
  bit [3:0] irq_p     = 4'd0;

  function automatic void m_offer(int tid, int rank, bit [7:0] tt);
    if (!m_pend[tid] || rank < m_rank[tid]) begin
      m_pend[tid] = 1'b1;
      m_rank[tid] = rank;
      m_tt[tid]   = tt;
    end
  endfunction

  task automatic step(input bit rv, input int rt, input bit [12:0] rvec,
                      input bit [6:0] ticc, input bit cv, input int ct,
                      input bit cet, input bit cfl);
    bit        found;
    bit [63:0] pv;
    snap_t     s;
    exp_t      e;
    @(negedge gclk);
    rstn               = rst_lvl;
    bus_if.req_valid   = rv;
    bus_if.req_tid     = 6'(rt);
    bus_if.req_vec     = rvec;
    bus_if.req_ticc    = ticc;
    bus_if.cmt_valid   = cv;
    bus_if.cmt_tid     = 6'(ct);
    bus_if.cmt_et      = cet;
    bus_if.cmt_flush   = cfl;
`ifdef THREAD_TRAP_IRQ_EN
    bus_if.irq_valid   = irq_v;
    bus_if.irq_tid     = 6'(irq_t);
    bus_if.irq_level   = irq_lvl;
    bus_if.irq_pil     = irq_p;
`endif
    if (!rst_lvl) begin
      for (int i = 0; i < NT; i++) begin
        m_pend[i] = 1'b0; m_tt[i] = 8'h00; m_rank[i] = 0;
      end
      m_err = '0;
    end else begin
      if (rv && rvec != 13'd0) begin
        found = 1'b0;
        for (int b = 0; b < 13; b++) begin
          if (!found && rvec[b]) begin
            found = 1'b1;
            m_offer(rt, b, (b == 12) ? {1'b1, ticc} : tt_tab[b]);
          end
        end
      end
`ifdef THREAD_TRAP_IRQ_EN
      if (irq_v && (irq_lvl > irq_p || irq_lvl == 4'd15))
        m_offer(irq_t, 13, 8'h10 + {4'd0, irq_lvl});
`endif
      if (cv) begin
        if (!cfl && m_pend[ct]) begin
          e.cyc = cyc + 1; e.err = !cet; e.tid = ct; e.tt = m_tt[ct];
          exp_q.push_back(e);
          if (!cet) m_err[ct] = 1'b1;
        end
        m_pend[ct] = 1'b0;
      end
    end
    for (int i = 0; i < NT; i++) pv[i] = m_pend[i];
    s.cyc = cyc + 1; s.pend = pv; s.err = m_err;
    snap_q.push_back(s);
    irq_v = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 13'd0, 7'd0, 0, 0, 1, 0);
  endtask

  task automatic req(input int tid, input int bitn, input bit [6:0] ticc);
    bit [12:0] v;
    v = 13'd0;
    v[bitn] = 1'b1;
    step(1, tid, v, ticc, 0, 0, 1, 0);
  endtask

  task automatic cmt(input int tid, input bit et, input bit fl);
    step(0, 0, 13'd0, 7'd0, 1, tid, et, fl);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  initial begin
    exp_t  e;
    snap_t s;
    bit    pulse;
    forever begin
      @(posedge gclk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missed_pulse cyc=%0d act=none exp=tid%0d tt%h err%0d", e.cyc, e.tid, e.tt, e.err);
      end
      pulse = (bus_if.trap_valid === 1'b1) || (bus_if.err_valid === 1'b1);
      if (pulse) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse cyc=%0d act=tv%b ev%b tid%0d tt%h exp=none",
                   cyc, bus_if.trap_valid, bus_if.err_valid, bus_if.trap_tid, bus_if.trap_tt);
        end else begin
          e = exp_q.pop_front();
          chk("kind", {62'd0, bus_if.trap_valid, bus_if.err_valid}, {62'd0, !e.err, e.err});
          chk("trap_tid", 64'(bus_if.trap_tid), 64'(e.tid));
          chk("trap_tt", 64'(bus_if.trap_tt), 64'(e.tt));
          $display("cyc %0d %s tid=%0d tt=%h", cyc, e.err ? "err " : "trap", bus_if.trap_tid, bus_if.trap_tt);
        end
      end
      if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
        s = snap_q.pop_front();
        chk("pend", bus_if.pend, s.pend);
        chk("err_mode", bus_if.err_mode, s.err);
        if (!pulse) begin
          chk("idle_valid", {62'd0, bus_if.trap_valid, bus_if.err_valid}, 64'd0);
          chk("idle_tid_tt", {50'd0, bus_if.trap_tid, bus_if.trap_tt}, 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int        t;
    int        ct;
    int        b0;
    bit [12:0] v;
    bus_if.req_valid = 0; bus_if.req_tid = 0; bus_if.req_vec = 0; bus_if.req_ticc = 0;
    bus_if.cmt_valid = 0; bus_if.cmt_tid = 0; bus_if.cmt_et = 0; bus_if.cmt_flush = 0;
`ifdef THREAD_TRAP_IRQ_EN
    bus_if.irq_valid = 0; bus_if.irq_tid = 0; bus_if.irq_level = 0; bus_if.irq_pil = 0;
`endif
    // Reset with request and commit active.
    rst_lvl = 1'b0;
    step(1, 4, 13'h0081, 7'd0, 1, 4, 1, 0);
    step(1, 4, 13'h0081, 7'd0, 1, 4, 1, 0);
    rst_lvl = 1'b1;
    idle(2);

    // UNALA on thread 5, then commit.
    req(5, 7, 7'd0); idle(1); cmt(5, 1, 0); idle(2);
    // TICC then DAEX, and the reverse order, on thread 3.
    req(3, 12, 7'h10); req(3, 9, 7'd0); cmt(3, 1, 0); idle(1);
    req(3, 9, 7'd0); req(3, 12, 7'h10); cmt(3, 1, 0); idle(1);
    // Bypass merge: WINOF pending, PRIV request in the commit cycle.
    req(7, 5, 7'd0); step(1, 7, 13'h0002, 7'd0, 1, 7, 1, 0); idle(1);
    req(7, 5, 7'd0); step(1, 7, 13'h0002, 7'd0, 1, 7, 1, 1); idle(1);
    // DIVZ with ET=0 enters error mode; a later request is still recorded.
    req(2, 11, 7'd0); cmt(2, 0, 0); idle(1);
    req(2, 10, 7'd0); cmt(2, 1, 0); idle(2);
    // Empty request vector has no effect.
    step(1, 9, 13'd0, 7'd0, 0, 0, 1, 0); cmt(9, 1, 0); idle(1);

`ifdef THREAD_TRAP_IRQ_EN
    irq_v = 1; irq_t = 1; irq_lvl = 4'd4;  irq_p = 4'd6;  idle(1); cmt(1, 1, 0); idle(1);
    irq_v = 1; irq_t = 1; irq_lvl = 4'd15; irq_p = 4'd15; idle(1); cmt(1, 1, 0); idle(1);
    irq_v = 1; irq_t = 1; irq_lvl = 4'd9;  irq_p = 4'd0;  req(1, 10, 7'd0); cmt(1, 1, 0); idle(1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_lvl = ($urandom_range(0, 499) != 0);
      t  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NT - 1);
      ct = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NT - 1);
      v  = 13'd0;
      if ($urandom_range(0, 3) != 0) begin
        b0 = $urandom_range(0, 12);
        v[b0] = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          b0 = $urandom_range(0, 12);
          v[b0] = 1'b1;
        end
      end
`ifdef THREAD_TRAP_IRQ_EN
      irq_v   = ($urandom_range(0, 9) < 3);
      irq_t   = $urandom_range(0, 7);
      irq_lvl = 4'($urandom_range(0, 15));
      irq_p   = 4'($urandom_range(0, 15));
`endif
      step($urandom_range(0, 9) < 6, t, v, 7'($urandom_range(0, 127)),
           $urandom_range(0, 9) < 4, ct, $urandom_range(0, 9) < 8,
           $urandom_range(0, 99) < 15);
    end
    rst_lvl = 1'b1;
    idle(3);

    // Final reset clears err_mode and pend.
    rst_lvl = 1'b0;
    idle(2);
    rst_lvl = 1'b1;
    idle(3);
    @(negedge gclk);
    @(negedge gclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected act=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thread_trap_ctrl.md
Name: thread_trap_ctrl

Overview:
- Per-thread trap collection and prioritisation unit for the multithreaded SPARC V8 integer pipeline.
- Accepts trap-request vectors from the execute/memory stages, tagged by thread ID.
- Keeps the highest-priority pending trap per thread, using SPARC V8 priority order.
- Emits a registered trap, or error-mode event, when that thread reaches commit. Supersedes ad-hoc per-stage TT muxing; NTHREAD threads are interleaved.

Parameters:
- NTHREAD, 64, number of hardware threads (power of two).
- TIDW, 6, thread-ID width, log2(NTHREAD).
- TTW, 8, trap-type width (full SPARC tt field).

Ports:
- gclk  in  1  pipeline clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  trap request strobe
- req_tid  in  TIDW  requesting thread
- req_vec  in  13  one-hot-or-more trap classes, bit0..12 = IAEX, PRIV, IINST, FPDIS, CPDIS, WINOF, WINUF, UNALA, FPEXC, DAEX, TAG, DIVZ, TICC
- req_ticc  in  7  software trap number for TICC
- cmt_valid  in  1  thread reaches commit
- cmt_tid  in  TIDW  committing thread
- cmt_et  in  1  PSR.ET of committing thread
- cmt_flush  in  1  discard pending trap of cmt_tid (replay/annul)
- trap_valid  out  1  trap taken pulse
- trap_tid  out  TIDW  thread taking trap
- trap_tt  out  TTW  tt value
- err_valid  out  1  trap with ET=0, error-mode entry pulse
- err_mode  out  NTHREAD  sticky per-thread error-mode flags
- pend  out  NTHREAD  per-thread pending flags (debug)

Behaviour:
- Reset (rstn=0 at gclk edge): all pend, err_mode, stored TT = 0; trap_valid = err_valid = 0; trap_tid = trap_tt = 0. Reset mid-operation drops all pending traps without emitting.
- Priority, highest first: IAEX > PRIV > IINST > FPDIS > CPDIS > WINOF > WINUF > UNALA > FPEXC > DAEX > TAG > DIVZ > TICC > IRQ. Stored alongside TT as a 4-bit rank (0 = highest).
- TT encoding:
  - IAEX 0x01, IINST 0x02, PRIV 0x03, FPDIS 0x04, WINOF 0x05, WINUF 0x06, UNALA 0x07, FPEXC 0x08, DAEX 0x09, TAG 0x0A.
  - CPDIS 0x24, DIVZ 0x2A.
  - TICC = {1'b1, req_ticc}.
- Request, req_valid=1 with req_vec≠0:
  - Encode the highest set bit-class into a candidate.
  - If pend[tid]=0, or the candidate rank is strictly higher than the stored rank: store the candidate and set pend.
  - Equal or lower rank: ignored; the first-arrived trap wins a tie.
- req_valid=1 with req_vec=0: no effect.
- Commit, cmt_valid=1: evaluate the effective pending state of cmt_tid.
  - Effective state includes a same-cycle request for the same tid (bypass merge by the priority rule above).
  - cmt_flush=1: clear pend[cmt_tid]; no output.
  - Else, if effective pending and cmt_et=1: next cycle trap_valid=1, trap_tid, trap_tt; clear pend.
  - Else, if effective pending and cmt_et=0: next cycle err_valid=1 with trap_tid/trap_tt; set err_mode[tid]; clear pend.
  - Not pending: outputs 0 next cycle.
- Latency: commit to trap_valid/err_valid = 1 cycle. Both outputs are single-cycle pulses and mutually exclusive.
- Request and commit for different tids in the same cycle: independent.
- A new request to a thread already in err_mode is still recorded; err_mode clears only on reset.
- State is stored in per-thread register arrays (LUTRAM-inferable, one write per port per cycle). The request path and the commit path write different entries; on a same-tid collision the commit clear takes precedence over the request write.

Optional Feature:
- Macro: THREAD_TRAP_IRQ_EN.
- Defined: adds inputs irq_valid (1), irq_tid (TIDW), irq_level (4), irq_pil (4).
  - An interrupt is accepted only when irq_level > irq_pil or irq_level == 15. It then becomes a candidate with TT = 0x10 + irq_level and lowest rank.
  - It merges with the per-thread pending state under the same rules. A same-tid req/irq collision in one cycle merges both, and the higher rank wins.
- Undefined: no IRQ ports; the IRQ rank is unused.

Test Plan:
- Reset: rstn=0 for 2 cycles with req/cmt active → all outputs 0, pend=0, err_mode=0.
- Thread 5 request UNALA (bit7), then commit tid5 ET=1 → next cycle trap_valid=1, trap_tid=5, trap_tt=0x07; pend[5]=0 afterwards.
- Thread 3 requests TICC n=0x10, later DAEX; commit → trap_tt=0x09. Reverse order (DAEX then TICC) → also 0x09.
- Same-cycle req tid7 PRIV and cmt tid7 with WINOF pending → trap_tt=0x03 (bypass merge); cmt_flush=1 instead → no pulse, pend[7]=0.
- Thread 2 DIVZ, commit with cmt_et=0 → err_valid=1, trap_tt=0x2A, err_mode[2]=1, trap_valid=0; err_mode persists until rstn=0.
- THREAD_TRAP_IRQ_EN: irq tid1 level 4 pil 6 → ignored. Level 15 pil 15 → commit trap_tt=0x1F. Level 9 plus TAG on the same tid → 0x0A.
